// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared widths, funct3 codes, FSM encodings and result-cache entry type
// used by the divider issue/retire controller.
package div_ctrl_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int FUNCT3_WIDTH   = 3;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [FUNCT3_WIDTH-1:0] INST_DIV  = 3'b100;
  localparam logic [FUNCT3_WIDTH-1:0] INST_DIVU = 3'b101;
  localparam logic [FUNCT3_WIDTH-1:0] INST_REM  = 3'b110;
  localparam logic [FUNCT3_WIDTH-1:0] INST_REMU = 3'b111;

  typedef enum logic [2:0] {
    DIVC_IDLE = 3'b001,
    DIVC_WAIT = 3'b010,
    DIVC_WB   = 3'b100
  } divc_state_e;

  typedef struct packed {
    logic [FUNCT3_WIDTH-1:0] op;
    logic [CPU_WIDTH-1:0]    rs1;
    logic [CPU_WIDTH-1:0]    rs2;
    logic [CPU_WIDTH-1:0]    result;
  } div_cache_entry_t;

  // x0 is hard-wired, so a write to it is suppressed.
  function automatic logic rd_writes(input logic [REG_ADDR_WIDTH-1:0] rd);
    return rd != {REG_ADDR_WIDTH{1'b0}};
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX request, divider handshake and register-file write-back bundle.
// master = EX/divider/regfile side, slave = div_ctrl.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                      req_valid_i;
  logic [FUNCT3_WIDTH-1:0]   req_op_i;
  logic [CPU_WIDTH-1:0]      req_rs1_i;
  logic [CPU_WIDTH-1:0]      req_rs2_i;
  logic [REG_ADDR_WIDTH-1:0] req_rd_i;
  logic                      flush_i;
  logic [CPU_WIDTH-1:0]      div_dividend_o;
  logic [CPU_WIDTH-1:0]      div_divisor_o;
  logic [FUNCT3_WIDTH-1:0]   div_op_o;
  logic                      div_start_o;
  logic [CPU_WIDTH-1:0]      div_result_i;
  logic                      div_ready_i;
  logic                      div_busy_i;
  logic                      hold_o;
  logic                      wb_we_o;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_o;
  logic [CPU_WIDTH-1:0]      wb_data_o;

  modport master (
    output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
    output div_result_i, div_ready_i, div_busy_i,
    input  div_dividend_o, div_divisor_o, div_op_o, div_start_o,
    input  hold_o, wb_we_o, wb_addr_o, wb_data_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
    input  div_result_i, div_ready_i, div_busy_i,
    output div_dividend_o, div_divisor_o, div_op_o, div_start_o,
    output hold_o, wb_we_o, wb_addr_o, wb_data_o
  );

endinterface

// File: rtl/div_result_cache.sv
// div_result_cache: one-entry {op, rs1, rs2, result} store with lookup compare.
// Compiled only when DIV_RESULT_CACHE_EN is defined.
`ifdef DIV_RESULT_CACHE_EN
module div_result_cache
  import div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [FUNCT3_WIDTH-1:0] wr_op_i,
  input  logic [CPU_WIDTH-1:0]    wr_rs1_i,
  input  logic [CPU_WIDTH-1:0]    wr_rs2_i,
  input  logic [CPU_WIDTH-1:0]    wr_result_i,
  input  logic [FUNCT3_WIDTH-1:0] lk_op_i,
  input  logic [CPU_WIDTH-1:0]    lk_rs1_i,
  input  logic [CPU_WIDTH-1:0]    lk_rs2_i,
  output logic                    hit_o,
  output logic [CPU_WIDTH-1:0]    hit_data_o
);

  logic             valid_q;
  div_cache_entry_t entry_q;

  // Only reset invalidates the entry; a flush leaves a completed result usable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= 1'b0;
      entry_q.op     <= {FUNCT3_WIDTH{1'b0}};
      entry_q.rs1    <= {CPU_WIDTH{1'b0}};
      entry_q.rs2    <= {CPU_WIDTH{1'b0}};
      entry_q.result <= {CPU_WIDTH{1'b0}};
    end else if (wr_en_i) begin
      valid_q        <= 1'b1;
      entry_q.op     <= wr_op_i;
      entry_q.rs1    <= wr_rs1_i;
      entry_q.rs2    <= wr_rs2_i;
      entry_q.result <= wr_result_i;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign hit_o      = valid_q && (entry_q.op == lk_op_i) &&
                      (entry_q.rs1 == lk_rs1_i) && (entry_q.rs2 == lk_rs2_i);
  assign hit_data_o = entry_q.result;

endmodule
`endif

// File: rtl/div_ctrl.sv
// div_ctrl: EX-side issue/retire controller for the 32-bit iterative divider.
// Optional DIV_RESULT_CACHE_EN adds a one-entry result cache that bypasses the divider.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave dbus
);

  divc_state_e               state_q;
  logic                      just_retired_q;
  logic                      wb_we_q;
  logic [CPU_WIDTH-1:0]      dividend_q;
  logic [CPU_WIDTH-1:0]      divisor_q;
  logic [CPU_WIDTH-1:0]      wb_data_q;
  logic [FUNCT3_WIDTH-1:0]   op_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  logic                 in_idle_s;
  logic                 in_wait_s;
  logic                 in_wb_s;
  logic                 issue_s;
  logic                 complete_s;
  logic                 hit_s;
  logic [CPU_WIDTH-1:0] hit_data_s;

  assign in_idle_s  = (state_q == DIVC_IDLE);
  assign in_wait_s  = (state_q == DIVC_WAIT);
  assign in_wb_s    = (state_q == DIVC_WB);
  assign issue_s    = in_idle_s && dbus.req_valid_i && !dbus.flush_i &&
                      !dbus.div_busy_i && !just_retired_q;
  assign complete_s = in_wait_s && dbus.div_ready_i && !dbus.flush_i;

`ifdef DIV_RESULT_CACHE_EN
  div_result_cache u_cache (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (complete_s),
    .wr_op_i     (op_q),
    .wr_rs1_i    (dividend_q),
    .wr_rs2_i    (divisor_q),
    .wr_result_i (dbus.div_result_i),
    .lk_op_i     (dbus.req_op_i),
    .lk_rs1_i    (dbus.req_rs1_i),
    .lk_rs2_i    (dbus.req_rs2_i),
    .hit_o       (hit_s),
    .hit_data_o  (hit_data_s)
  );
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = {CPU_WIDTH{1'b0}};
`endif

  // Controller FSM with operand latches and registered write-back port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= DIVC_IDLE;
      just_retired_q <= 1'b0;
      wb_we_q        <= 1'b0;
      dividend_q     <= {CPU_WIDTH{1'b0}};
      divisor_q      <= {CPU_WIDTH{1'b0}};
      wb_data_q      <= {CPU_WIDTH{1'b0}};
      op_q           <= {FUNCT3_WIDTH{1'b0}};
      rd_q           <= {REG_ADDR_WIDTH{1'b0}};
    end else begin
      // The retiring instruction is still presented by EX for one more cycle.
      just_retired_q <= in_wb_s && !dbus.flush_i;
      wb_we_q        <= 1'b0;
      if (dbus.flush_i) begin
        state_q <= DIVC_IDLE;
      end else begin
        case (state_q)
          DIVC_IDLE: begin
            if (issue_s) begin
              dividend_q <= dbus.req_rs1_i;
              divisor_q  <= dbus.req_rs2_i;
              op_q       <= dbus.req_op_i;
              rd_q       <= dbus.req_rd_i;
              if (hit_s) begin
                state_q   <= DIVC_WB;
                wb_data_q <= hit_data_s;
                wb_we_q   <= rd_writes(dbus.req_rd_i);
              end else begin
                state_q <= DIVC_WAIT;
              end
            end else begin
              state_q <= DIVC_IDLE;
            end
          end
          DIVC_WAIT: begin
            if (dbus.div_ready_i) begin
              wb_data_q <= dbus.div_result_i;
              wb_we_q   <= rd_writes(rd_q);
              state_q   <= DIVC_WB;
            end else begin
              state_q <= DIVC_WAIT;
            end
          end
          DIVC_WB: state_q <= DIVC_IDLE;
          default: state_q <= DIVC_IDLE;
        endcase
      end
    end
  end

  // Start drops in the ready cycle so the divider does not relaunch.
  assign dbus.div_start_o    = in_wait_s && !dbus.div_ready_i && !dbus.flush_i;
  assign dbus.hold_o         = !dbus.flush_i &&
                               ((in_idle_s && dbus.req_valid_i && !just_retired_q) || in_wait_s);
  assign dbus.div_dividend_o = dividend_q;
  assign dbus.div_divisor_o  = divisor_q;
  assign dbus.div_op_o       = op_q;
  assign dbus.wb_we_o        = wb_we_q && !dbus.flush_i;
  assign dbus.wb_addr_o      = rd_q;
  assign dbus.wb_data_o      = wb_data_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: div_ctrl with a timing-accurate divider stand-in, a transaction-level
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if dif ();
  div_ctrl dut (.clk(clk), .rst(rst), .dbus(dif.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // RISC-V M-extension division semantics.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      INST_DIV: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        else return $unsigned(sa / sb);
      end
      INST_DIVU: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      INST_REM: begin
        if (b == 32'd0) return a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        else return $unsigned(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Divider stand-in: ready 35 cycles after start first seen (2 for divisor zero); start low aborts.
  logic [7:0] dcnt_q;
  logic [7:0] dlat_s;
  always @(posedge clk or posedge rst) begin
    if (rst) dcnt_q <= 8'd0;
    else if (dif.div_start_o) dcnt_q <= dcnt_q + 8'd1;
    else dcnt_q <= 8'd0;
  end
  assign dlat_s           = (dif.div_divisor_o == 32'd0) ? 8'd2 : 8'd35;
  assign dif.div_ready_i  = (dcnt_q != 8'd0) && (dcnt_q == dlat_s);
  assign dif.div_busy_i   = (dcnt_q != 8'd0);
  assign dif.div_result_i = ref_div(dif.div_op_o, dif.div_dividend_o, dif.div_divisor_o);

  // Transaction model: each accepted request owns the cycles [issue, wb].
  int          cyc;
  bit          m_active;
  int          m_t_issue;
  int          m_t_wb;
  int          m_last_ret;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  bit          m_hit;
  logic        exp_hold;
  logic        exp_start;
  logic        exp_we;
  bit          jr;
`ifdef DIV_RESULT_CACHE_EN
  bit          c_valid;
  logic [2:0]  c_op;
  logic [31:0] c_a;
  logic [31:0] c_b;
  logic [31:0] c_r;
  logic [2:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
`endif

  always @(negedge clk) begin
    if (rst) begin
      cyc        = 0;
      m_active   = 1'b0;
      m_last_ret = -10;
`ifdef DIV_RESULT_CACHE_EN
      c_valid    = 1'b0;
`endif
    end else begin
      exp_hold  = 1'b0;
      exp_start = 1'b0;
      exp_we    = 1'b0;
      jr        = (cyc == m_last_ret + 1);
      if (m_active) begin
        if (cyc == m_t_wb) begin
          exp_we   = (m_rd != 5'd0) && !dif.flush_i;
          m_active = 1'b0;
          if (!dif.flush_i) m_last_ret = cyc;
        end else begin
          exp_hold  = !dif.flush_i;
          exp_start = (cyc < m_t_wb - 1) && !dif.flush_i;
          if (dif.flush_i) m_active = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
          else if (cyc == m_t_wb - 1) begin
            c_valid = 1'b1; c_op = m_op; c_a = m_a; c_b = m_b; c_r = m_res;
          end
`endif
        end
      end else begin
        exp_hold = dif.req_valid_i && !dif.flush_i && !jr;
        if (exp_hold && !dif.div_busy_i) begin
          m_active  = 1'b1;
          m_t_issue = cyc;
          m_rd      = dif.req_rd_i;
          m_res     = ref_div(dif.req_op_i, dif.req_rs1_i, dif.req_rs2_i);
          m_hit     = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
          m_op  = dif.req_op_i;
          m_a   = dif.req_rs1_i;
          m_b   = dif.req_rs2_i;
          m_hit = c_valid && c_op == m_op && c_a == m_a && c_b == m_b;
`endif
          m_t_wb = m_hit ? cyc + 1 : ((dif.req_rs2_i == 32'd0) ? cyc + 4 : cyc + 37);
        end
      end
      chk("hold_o", 32'(dif.hold_o), 32'(exp_hold));
      chk("div_start_o", 32'(dif.div_start_o), 32'(exp_start));
      chk("wb_we_o", 32'(dif.wb_we_o), 32'(exp_we));
      if (exp_we) begin
        chk("wb_addr_o", 32'(dif.wb_addr_o), 32'(m_rd));
        chk("wb_data_o", dif.wb_data_o, m_res);
      end
      cyc++;
    end
  end

  // Present one instruction like EX would; returns observed timing relative to T0.
  task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int flush_at,
                         output int done_off, output int we_off, output logic [31:0] we_data,
                         output logic [4:0] we_addr, output int hold_cnt, output int start_cnt);
    bit fin;
    fin = 1'b0;
    done_off = -1; we_off = -1; we_data = 32'd0; we_addr = 5'd0; hold_cnt = 0; start_cnt = 0;
    for (int k = 0; k < 80 && !fin; k++) begin
      @(posedge clk); #1;
      dif.req_valid_i = 1'b1;
      dif.req_op_i    = op;
      dif.req_rs1_i   = a;
      dif.req_rs2_i   = b;
      dif.req_rd_i    = rd;
      dif.flush_i     = (k == flush_at);
      @(negedge clk);
      if (dif.hold_o) hold_cnt++;
      if (dif.div_start_o) start_cnt++;
      if (dif.wb_we_o) begin
        we_off = k; we_data = dif.wb_data_o; we_addr = dif.wb_addr_o;
      end
      if (done_off >= 0) fin = 1'b1;
      else if (k > 0 && !dif.hold_o) begin
        done_off = k;
        if (k == flush_at) fin = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd7;
      4: return 32'd1000;
      5: return 32'd10;
      default: return $urandom;
    endcase
  endfunction

`ifdef DIV_RESULT_CACHE_EN
  localparam int REPEAT_LAT   = 1;
  localparam int REPEAT_START = 0;
`else
  localparam int REPEAT_LAT   = 37;
  localparam int REPEAT_START = 35;
`endif

  int          d_done, d_we, d_hold, d_start;
  logic [31:0] d_data;
  logic [4:0]  d_addr;

  initial begin
    dif.req_valid_i = 1'b0;
    dif.req_op_i    = 3'd0;
    dif.req_rs1_i   = 32'd0;
    dif.req_rs2_i   = 32'd0;
    dif.req_rd_i    = 5'd0;
    dif.flush_i     = 1'b0;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst hold_o", 32'(dif.hold_o), 32'd0);
    chk("rst div_start_o", 32'(dif.div_start_o), 32'd0);
    chk("rst wb_we_o", 32'(dif.wb_we_o), 32'd0);
    chk("rst wb_addr_o", 32'(dif.wb_addr_o), 32'd0);
    chk("rst wb_data_o", dif.wb_data_o, 32'd0);
    chk("rst div_dividend_o", dif.div_dividend_o, 32'd0);
    chk("rst div_divisor_o", dif.div_divisor_o, 32'd0);
    chk("rst div_op_o", 32'(dif.div_op_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    chk("ref DIV -7/2", ref_div(INST_DIV, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    chk("ref REMU x/0", ref_div(INST_REMU, 32'h80000000, 32'd0), 32'h80000000);
    chk("ref DIVU 5/0", ref_div(INST_DIVU, 32'd5, 32'd0), 32'hFFFFFFFF);
    chk("ref REM 10/3", ref_div(INST_REM, 32'd10, 32'd3), 32'd1);
    chk("ref DIV ovf", ref_div(INST_DIV, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);

    run_req(INST_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, -1, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("div -7/2 wb cycle", d_we, 32'd37);
    chk("div -7/2 data", d_data, 32'hFFFFFFFD);
    chk("div -7/2 addr", 32'(d_addr), 32'd5);
    chk("div -7/2 hold cycles", d_hold, 32'd37);
    chk("div -7/2 start cycles", d_start, 32'd35);

    run_req(INST_REMU, 32'h80000000, 32'd0, 5'd3, -1, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("remu /0 wb cycle", d_we, 32'd4);
    chk("remu /0 data", d_data, 32'h80000000);
    chk("remu /0 start cycles", d_start, 32'd2);

    run_req(INST_DIVU, 32'd5, 32'd0, 5'd7, -1, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("divu /0 wb cycle", d_we, 32'd4);
    chk("divu /0 data", d_data, 32'hFFFFFFFF);

    run_req(INST_DIV, 32'd100, 32'd7, 5'd9, 20, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("flush T20 no wb", d_we, 32'hFFFFFFFF);
    chk("flush T20 end", d_done, 32'd20);
    chk("flush T20 start cycles", d_start, 32'd19);
    run_req(INST_DIVU, 32'd9, 32'd3, 5'd10, -1, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("after flush wb cycle", d_we, 32'd37);
    chk("after flush data", d_data, 32'd3);

    run_req(INST_DIV, 32'd50, 32'd5, 5'd11, 36, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("flush+ready no wb", d_we, 32'hFFFFFFFF);
    chk("flush+ready end", d_done, 32'd36);
    run_req(INST_DIVU, 32'd20, 32'd4, 5'd12, -1, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("after flush+ready wb cycle", d_we, 32'd37);
    chk("after flush+ready data", d_data, 32'd5);

    run_req(INST_REM, 32'd10, 32'd3, 5'd0, -1, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("rd0 no wb", d_we, 32'hFFFFFFFF);
    chk("rd0 latency", d_done, 32'd37);

    run_req(INST_DIVU, 32'd1000, 32'd10, 5'd13, -1, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("divu 1000/10 first wb", d_we, 32'd37);
    chk("divu 1000/10 first data", d_data, 32'd100);
    run_req(INST_DIVU, 32'd1000, 32'd10, 5'd13, -1, d_done, d_we, d_data, d_addr, d_hold, d_start);
    chk("divu 1000/10 repeat wb", d_we, REPEAT_LAT);
    chk("divu 1000/10 repeat data", d_data, 32'd100);
    chk("divu 1000/10 repeat start", d_start, REPEAT_START);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      dif.flush_i = ($urandom_range(39) == 0);
      if (!m_active && $urandom_range(2) == 0) begin
        dif.req_valid_i = ($urandom_range(3) != 0);
        if ($urandom_range(1) == 0) begin
          dif.req_op_i  = INST_DIV + 3'($urandom_range(3));
          dif.req_rs1_i = pick_val();
          dif.req_rs2_i = pick_val();
        end
        dif.req_rd_i = 5'($urandom_range(31));
      end
    end
    @(posedge clk); #1;
    dif.req_valid_i = 1'b0;
    dif.flush_i     = 1'b0;
    repeat (50) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1);
  end

endmodule
